// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
// Write-back register file: 32 x XLEN integer registers with x0 hard-wired to
// zero. It commits the W-stage result when RegWEn is set, serves two
// combinational operand read ports to the D stage, exposes a debug read port
// and counts committed writes since reset.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : write-before-read. A same-cycle write is forwarded to rs1/rs2.
//   undefined : rs1/rs2 return the pre-edge value. W->D forwarding is external.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset (clears x1..x31, wr_count)
//   RegWEn    in   1      commit wb_data to rd_addr at the next rising edge
//   rd_addr   in   AW     destination register (W-stage inst[11:7])
//   wb_data   in   XLEN   write-back data
//   rs1_addr  in   AW     read port 1 address (D-stage inst[19:15])
//   rs2_addr  in   AW     read port 2 address (D-stage inst[24:20])
//   rs1_data  out  XLEN   read port 1 data (combinational)
//   rs2_data  out  XLEN   read port 2 data (combinational)
//   dbg_addr  in   AW     debug read address
//   dbg_data  out  XLEN   debug read data (combinational, never bypassed)
//   wr_count  out  CNT_W  committed writes since reset, wraps silently
//
// NREGS is expected to be a power of two so every address selects a register.
// ---------------------------------------------------------------------------
module reg_file_wb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWEn,
  input  logic [AW-1:0]    rd_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [CNT_W-1:0] wr_count
);

  // x0 has no storage; only x1..x(NREGS-1) are real flops.
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic            wrEn;
  logic [XLEN-1:0] rs1Stored;
  logic [XLEN-1:0] rs2Stored;

  // A write to x0 is discarded and is not counted as a commit.
  assign wrEn = RegWEn && (rd_addr != '0);

  // Register array: async clear, one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[rd_addr] <= wb_data;
    end
  end

  // Committed-write counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wrEn) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Stored-value lookups with x0 forced to zero.
  always_comb begin
    rs1Stored = '0;
    if (rs1_addr != '0) begin
      rs1Stored = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2Stored = '0;
    if (rs2_addr != '0) begin
      rs2Stored = regs[rs2_addr];
    end
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = regs[dbg_addr];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-before-read: wrEn already excludes x0, so x0 still reads zero.
  always_comb begin
    rs1_data = rs1Stored;
    if (wrEn && (rs1_addr == rd_addr)) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = rs2Stored;
    if (wrEn && (rs2_addr == rd_addr)) begin
      rs2_data = wb_data;
    end
  end
`else
  // Read-before-write: new value appears the cycle after the commit edge.
  assign rs1_data = rs1Stored;
  assign rs2_data = rs2Stored;
`endif

endmodule
